// File: rtl/hazard_ctrl.sv
// Hazard/scheduling controller for the 5-stage MIPS core: operand forwarding,
// load-use / branch / MDU stalls, IF/ID and ID/EX flushes, and the MDU busy FSM.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        MemtoRegM,
  input  logic        BranchD,
  input  logic        PCSrcD,
  input  logic        MduStartE,
  input  logic        MduDivE,
  input  logic        MduUseD,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic        MduBusy,
  output logic        MduDone,
  output logic [15:0] StallCnt,
  output logic [1:0]  o_dbg_mdu_state
);

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

  localparam logic [CNT_W-1:0] LP_MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  mdu_state_t       r_state;
  mdu_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [15:0]      r_stall_cnt;

  logic w_m_valid, w_w_valid, w_e_valid, w_ld_m_valid;
  logic w_lwstall, w_brstall, w_mdustall, w_stall;
  logic [1:0] w_fwd_ae, w_fwd_be;

  // Register $zero is hardwired, so a write to it never creates a dependency.
  assign w_m_valid    = RegWriteM && (WriteRegM != 5'd0);
  assign w_w_valid    = RegWriteW && (WriteRegW != 5'd0);
  assign w_e_valid    = RegWriteE && (WriteRegE != 5'd0);
  assign w_ld_m_valid = MemtoRegM && (WriteRegM != 5'd0);

  always_comb begin
    w_fwd_ae = 2'b00;
    if (w_m_valid && (WriteRegM == RsE))      w_fwd_ae = 2'b10;
    else if (w_w_valid && (WriteRegW == RsE)) w_fwd_ae = 2'b01;
  end

  always_comb begin
    w_fwd_be = 2'b00;
    if (w_m_valid && (WriteRegM == RtE))      w_fwd_be = 2'b10;
    else if (w_w_valid && (WriteRegW == RtE)) w_fwd_be = 2'b01;
  end

  assign w_lwstall = MemtoRegE && (WriteRegE != 5'd0) &&
                     ((WriteRegE == RsD) || (WriteRegE == RtD));

  // Branches compare in ID, so an ALU result still in EX or a load in MEM is too late.
  assign w_brstall = BranchD &&
                     ((w_e_valid && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                      (w_ld_m_valid && ((WriteRegM == RsD) || (WriteRegM == RtD))));

  assign w_mdustall = MduUseD && (r_state == MDU_RUN);
  assign w_stall    = rst_n && (w_lwstall || w_brstall || w_mdustall);

  assign ForwardAE = rst_n ? w_fwd_ae : 2'b00;
  assign ForwardBE = rst_n ? w_fwd_be : 2'b00;
  assign ForwardAD = rst_n && w_m_valid && (WriteRegM == RsD);
  assign ForwardBD = rst_n && w_m_valid && (WriteRegM == RtD);
  assign StallF    = w_stall;
  assign StallD    = w_stall;
  assign FlushE    = w_stall;
  // A stalled taken branch is not flushed yet; it re-resolves next cycle.
  assign FlushD    = rst_n && PCSrcD && !w_stall;

  // MduStartE is a single-cycle pulse from EX; it is only honoured outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MDU_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      MDU_IDLE, MDU_DONE: begin
        w_state_nxt = MDU_IDLE;
        if (MduStartE) begin
          w_state_nxt = MDU_RUN;
          w_cnt_nxt   = MduDivE ? LP_DIV_LOAD : LP_MULT_LOAD;
        end
      end
      MDU_RUN: begin
        if (r_cnt == '0) w_state_nxt = MDU_DONE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: begin
        w_state_nxt = MDU_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign MduBusy         = rst_n && (r_state == MDU_RUN);
  assign MduDone         = rst_n && (r_state == MDU_DONE);
  assign o_dbg_mdu_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign StallCnt = r_stall_cnt;

endmodule
